// File: rtl/display_scan_controller.sv
// -----------------------------------------------------------------------------
// display_scan_controller
//
// Multiplexed hex display scanner. A prescaler divides clk into digit slots of
// CLK_DIV cycles; on every slot boundary the scan position advances through
// 0..NUM_DIGITS-1 and wraps. A new 32-bit value is staged on `load` and only
// becomes the displayed (active) value at a frame boundary (position wrapping
// to 0), so a frame never shows a mix of old and new nibbles.
//
// Parameters:
//   CLK_DIV     clk cycles per digit slot (2..2^24)
//   NUM_DIGITS  digits scanned per frame (1..8)
//
// Ports:
//   clk       in   sole clock, rising edge
//   rst       in   synchronous active-high reset
//   value     in   [31:0] hex value, nibble i belongs to digit position i
//   load      in   single-cycle request to stage `value`
//   load_ack  out  one-cycle pulse when the staged value becomes active
//   digit     out  [3:0] nibble of the active value at the current position
//   position  out  [2:0] current digit index
//   blank     out  current digit must not be lit
//
// Build option:
//   LEADING_ZERO_BLANK_EN  when defined, blank suppresses leading zeros
//                          (position 0 is never blanked). When undefined,
//                          blank is tied low.
// -----------------------------------------------------------------------------
module display_scan_controller #(
  parameter int CLK_DIV    = 100000,
  parameter int NUM_DIGITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] value,
  input  logic        load,
  output logic        load_ack,
  output logic [3:0]  digit,
  output logic [2:0]  position,
  output logic        blank
);

  localparam logic [23:0] PRESC_MAX = 24'(CLK_DIV - 1);
  localparam logic [2:0]  POS_MAX   = 3'(NUM_DIGITS - 1);

  logic [23:0] prescaler_q, prescaler_d;
  logic [2:0]  position_q,  position_d;
  logic [31:0] staged_q,    staged_d;
  logic [31:0] active_q,    active_d;
  logic        pending_q,   pending_d;
  logic        load_ack_q,  load_ack_d;

  logic tick;
  logic wrap;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    tick = (prescaler_q == PRESC_MAX);
    wrap = tick && (position_q == POS_MAX);

    prescaler_d = tick ? 24'd0 : prescaler_q + 24'd1;

    position_d = position_q;
    if (tick) begin
      position_d = wrap ? 3'd0 : position_q + 3'd1;
    end

    staged_d   = load ? value : staged_q;
    pending_d  = pending_q;
    active_d   = active_q;
    load_ack_d = 1'b0;

    // Commit at the frame boundary. load_ack is registered so it is high in
    // the same cycle position first reads 0 with the new active value.
    if (wrap && pending_q) begin
      active_d   = staged_q;
      pending_d  = 1'b0;
      load_ack_d = 1'b1;
    end

    // A load on the commit edge stages the new value after the old one has
    // been committed above, so pending stays set for the next frame.
    if (load) begin
      pending_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values. Every register here is plain
  // control/data state (no memory array), so all of it is reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler_q <= '0;
      position_q  <= '0;
      staged_q    <= '0;
      active_q    <= '0;
      pending_q   <= 1'b0;
      load_ack_q  <= 1'b0;
    end else begin
      prescaler_q <= prescaler_d;
      position_q  <= position_d;
      staged_q    <= staged_d;
      active_q    <= active_d;
      pending_q   <= pending_d;
      load_ack_q  <= load_ack_d;
    end
  end

  assign position = position_q;
  assign load_ack = load_ack_q;
  assign digit    = active_q[{position_q, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
  // Blank when this and every higher scanned nibble is zero; position 0 is
  // always lit so a value of 0 still shows a single "0".
  logic upper_zero;

  always_comb begin
    upper_zero = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if ((i < NUM_DIGITS) && (i >= int'(position_q)) &&
          (active_q[4*i +: 4] != 4'h0)) begin
        upper_zero = 1'b0;
      end
    end
  end

  assign blank = (position_q != 3'd0) && upper_zero;
`else
  assign blank = 1'b0;
`endif

endmodule

// File: doc/display_scan_controller.md
DISPLAY_SCAN_CONTROLLER -- requirements
Module: display_scan_controller

Interface
REQ-001 Parameter CLK_DIV, default 100000: clk cycles per digit slot; legal range 2..2^24.
REQ-002 Parameter NUM_DIGITS, default 8: digits scanned per frame; legal range 1..8.
REQ-003 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port value  input  32  hex value to display; nibble i (value[4i+3:4i]) belongs to digit position i.
REQ-006 Port load  input  1  single-cycle request to stage `value` for display.
REQ-007 Port load_ack  output  1  one-cycle pulse when a staged value becomes the displayed value.
REQ-008 Port digit  output  4  nibble for the current position; feeds the downstream segment decoder's digit select.
REQ-009 Port position  output  3  current digit index; feeds the downstream decoder's position select.
REQ-010 Port blank  output  1  high when the current digit must not be lit.

Function
REQ-011 The block SHALL hold a prescaler counting 0..CLK_DIV-1 and SHALL return it to 0 after CLK_DIV-1.
REQ-012 The block SHALL assert an internal tick in the cycle the prescaler equals CLK_DIV-1.
REQ-013 On tick, position SHALL increment by 1, or SHALL wrap to 0 when it equals NUM_DIGITS-1.
REQ-014 Position SHALL never exceed NUM_DIGITS-1; for NUM_DIGITS=1 it SHALL stay at 0.
REQ-015 A wrap of position to 0 SHALL be a frame boundary.
REQ-016 The block SHALL keep a staged register, an active register (32 bits each) and a pending flag.
REQ-017 load=1 SHALL write value into staged and set pending on the next edge.
REQ-018 A load while pending=1 SHALL overwrite staged; only the latest value is displayed, with exactly one load_ack.
REQ-019 At a frame boundary with pending=1, active SHALL take staged, pending SHALL clear, and load_ack SHALL be 1 for exactly that one cycle.
REQ-020 load_ack SHALL be 1 in the same cycle that position first reads 0 with the new active value.
REQ-021 If load coincides with a commit edge, the previously staged value SHALL commit, the new value SHALL be staged, and pending SHALL remain 1.
REQ-022 digit SHALL equal active[4*position+3 : 4*position], combinationally from registered position and active.
REQ-023 digit and position SHALL change on the same edge; there SHALL be no partial-frame tearing of active.

Reset
REQ-024 While rst=1 at an edge, the prescaler, position, staged, active, pending and load_ack SHALL all go to 0; load SHALL be ignored.
REQ-025 After reset, digit=0, position=0, load_ack=0 and blank=0.
REQ-026 Reset mid-frame SHALL discard any pending value with no load_ack.
REQ-027 The first tick after rst deasserts SHALL occur CLK_DIV cycles after the first non-reset edge.

Configuration
REQ-028 Macro LEADING_ZERO_BLANK_EN defined: blank SHALL be 1 when position>0 and every nibble of active at indices position..NUM_DIGITS-1 is 0.
REQ-029 With LEADING_ZERO_BLANK_EN defined, position 0 SHALL never be blanked, so a value of 0 displays a single "0".
REQ-030 Macro LEADING_ZERO_BLANK_EN undefined: blank SHALL be tied to 0 and no blanking logic SHALL exist.

Verification (CLK_DIV=4, NUM_DIGITS=4 unless stated)
REQ-031 Reset then idle: position SHALL step 0,1,2,3,0 every 4 cycles; digit=0; load_ack never pulses.
REQ-032 Load 32'h0000_1234 while position=1: digit SHALL stay 0 until the wrap; at the wrap load_ack=1 for one cycle; positions 0..3 then show digits 4,3,2,1.
REQ-033 Load 32'h1111 then 32'h2222 within one frame: every digit SHALL show 2 after the wrap, with a single load_ack.
REQ-034 Load 32'hAAAA on the commit edge of a pending 32'h5555: the frame SHALL show 5, and the next frame SHALL show A with a second load_ack.
REQ-035 With LEADING_ZERO_BLANK_EN, load 32'h0005: blank SHALL be 0 at position 0 and 1 at positions 1..3; load 0: blank SHALL be 0 at position 0 with digit 0.
REQ-036 Assert rst for one cycle at position 2 with a value pending: position and prescaler SHALL return to 0, active SHALL stay 0, and load_ack SHALL never pulse.
